traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Phase controller that owns the shared 7-bit interval timer in the intersection datapath. It drives the timer's reference value and restart, and consumes the timer's one-cycle `trigger`. It walks a main/side-road light cycle with an optional latched pedestrian phase and a flashing-yellow maintenance mode. One sequencer drives exactly one timer instance, and no other block writes the timer's `ref` or restart.

## Interface
Parameters:
- `MAIN_GREEN_T`, default 30: main-road green dwell, in timer units (1..128).
- `SIDE_GREEN_T`, default 20: side-road green dwell.
- `YELLOW_T`, default 5: yellow dwell for both roads.
- `ALLRED_T`, default 2: all-red clearance dwell.
- `WALK_T`, default 10: pedestrian walk dwell.
- `FLASH_T`, default 4: half-period of the flash blink.

Ports:
- `clock`, in, 1: system clock; all state changes on its rising edge.
- `reset`, in, 1: reset; asynchronous, active-high.
- `ped_req`, in, 1: pedestrian button; a 1 sampled on any clock edge is latched.
- `flash_mode`, in, 1: maintenance request, level-sensitive.
- `tmr_trigger`, in, 1: timer expiry pulse.
- `tmr_ref`, out, 7: reference value presented to the timer.
- `tmr_clear`, out, 1: registered restart pulse to the timer's reset input.
- `main_light`, out, 3: main-road lamp, one-hot {red, yellow, green}.
- `side_light`, out, 3: side-road lamp, one-hot {red, yellow, green}.
- `walk`, out, 1: pedestrian walk lamp.
- `ped_pending`, out, 1: pedestrian latch state.
- `phase`, out, 3: current state encoding, for debug.

## Operation
States and encodings:
- `MAIN_G` = 0
- `MAIN_Y` = 1
- `RED_A` = 2
- `SIDE_G` = 3
- `SIDE_Y` = 4
- `RED_B` = 5
- `WALK` = 6
- `FLASH` = 7

Transitions (taken only on a clock edge where `tmr_trigger`=1 and `tmr_clear`=0):
- `MAIN_G` → `MAIN_Y` → `RED_A` → `SIDE_G` → `SIDE_Y` → `RED_B`.
- `RED_B` → `WALK` if `ped_pending`=1, else → `MAIN_G`. `WALK` → `MAIN_G`.
- From `RED_A` or `RED_B` only: `flash_mode`=1 overrides the above and goes → `FLASH`.
- `FLASH` → `RED_B` when `flash_mode`=0 at a trigger, else stays in `FLASH` and toggles the blink bit.

Entering a state (including re-entering `FLASH`):
- `tmr_ref` is set to the state's dwell − 1.
- `tmr_clear` is held at 1 for exactly one cycle.
- A `tmr_trigger` seen during the `tmr_clear` cycle is ignored.

Lamps:
- Main-road lamp: green only in `MAIN_G`; yellow in `MAIN_Y`; red in every other state.
- Side-road lamp: green only in `SIDE_G`; yellow in `SIDE_Y`; red otherwise.
- `walk`=1 only in `WALK`; both roads are red there.
- `FLASH`: both lamps are yellow when the blink bit is 1 and all-off (3'b000) when it is 0. The blink bit is 1 on entry.
- A green on both roads at once is forbidden in every state.

Pedestrian latch:
- Set by `ped_req`=1.
- Cleared on the edge that enters `WALK`.
- If `ped_req`=1 on that same edge, the latch stays set; the request is served on the next cycle.

Arithmetic: dwell − 1 is computed in 7 bits. A dwell of 128 maps to `tmr_ref`=127.

## Timing
Reset values (immediate, asynchronous):
- State `RED_B`, with `tmr_ref` = `ALLRED_T` − 1 and `tmr_clear`=1 for the first cycle after reset releases.
- `main_light` = `side_light` = 3'b100.
- `walk`=0, `ped_pending`=0, blink bit=0.
- First post-reset green is `MAIN_G`, unless `flash_mode` is high or a pedestrian request has been latched.

Dwell:
- A state with dwell D lasts exactly D + 2 cycles: 1 clear cycle, then D count cycles, then 1 trigger cycle.
- The state change and the lamp change land on the edge that samples the trigger.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-phase returns the block to the reset values immediately, regardless of state.
- `flash_mode` asserted while in a green or yellow state takes effect at the next `RED_A` or `RED_B` boundary, never mid-green.

## Test plan
- Reset, then free-run with all parameters 2 and no inputs → phase sequence 5,0,1,2,3,4,5,0, each state 4 cycles; `tmr_clear` pulses once per state.
- `ped_req` pulsed for 1 cycle during `SIDE_G` (`WALK_T`=3) → `ped_pending`=1 until the `RED_B` exit; then `WALK` for 5 cycles with `walk`=1 and both lamps 3'b100; then `MAIN_G`.
- `flash_mode`=1 raised mid-`MAIN_G` → stays green to full dwell, then `MAIN_Y`, `RED_A`, `FLASH`. Lamps go 010/010, then 000/000, alternating every `FLASH_T`+2 cycles. Dropping `flash_mode` → `RED_B`, then `MAIN_G`.
- `ped_req`=1 on the exact edge entering `WALK` → `ped_pending` stays 1, and `WALK` repeats after the next full cycle.
- Asynchronous reset asserted mid-`SIDE_Y` → lamps 100/100 and `phase`=5 with no clock edge; the normal sequence resumes after release.
- Stray `tmr_trigger` forced high during a `tmr_clear` cycle → no state change; a lamp-conflict assertion (both greens) never fires across 10,000 random `ped_req`/`flash_mode` cycles.

Source files
------------

// File: rtl/traffic_phase_sequencer_if.sv
// Timer link between the phase sequencer and its dedicated interval timer.
//   tmr_ref     : reference (dwell - 1) presented to the timer
//   tmr_clear   : one-cycle restart pulse to the timer's reset input
//   tmr_trigger : one-cycle expiry pulse from the timer
// master = sequencer side, slave = timer side.
interface traffic_phase_sequencer_if;
  logic [6:0] tmr_ref;
  logic       tmr_clear;
  logic       tmr_trigger;

  modport master (
    output tmr_ref,
    output tmr_clear,
    input  tmr_trigger
  );

  modport slave (
    input  tmr_ref,
    input  tmr_clear,
    output tmr_trigger
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer. Owns the shared 7-bit interval timer: loads
// its reference and restarts it on every state entry, and advances on the
// timer's expiry pulse. Cycles main/side road lights with an optional latched
// pedestrian walk phase and a flashing-yellow maintenance mode.
// Ports:
//   clock, reset     : clock; asynchronous active-high reset
//   ped_req          : pedestrian button, latched on any sampled 1
//   flash_mode       : maintenance request (level), honoured at all-red phases
//   tmr              : timer link (tmr_ref, tmr_clear out; tmr_trigger in)
//   main_light       : main-road lamp, one-hot {red, yellow, green}
//   side_light       : side-road lamp, one-hot {red, yellow, green}
//   walk             : pedestrian walk lamp
//   ped_pending      : pedestrian latch state
//   phase            : current state encoding (debug)
// All outputs are registered.
module traffic_phase_sequencer #(
  parameter int unsigned MAIN_GREEN_T = 30,
  parameter int unsigned SIDE_GREEN_T = 20,
  parameter int unsigned YELLOW_T     = 5,
  parameter int unsigned ALLRED_T     = 2,
  parameter int unsigned WALK_T       = 10,
  parameter int unsigned FLASH_T      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ped_req,
  input  logic                        flash_mode,
  traffic_phase_sequencer_if.master   tmr,
  output logic [2:0]                  main_light,
  output logic [2:0]                  side_light,
  output logic                        walk,
  output logic                        ped_pending,
  output logic [2:0]                  phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    WALK   = 3'd6,
    FLASH  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Dwell - 1 truncated to 7 bits; a dwell of 128 lands on 127.
  function automatic logic [6:0] dwell_ref(input state_t s);
    logic [6:0] r;
    unique case (s)
      MAIN_G:         r = 7'(MAIN_GREEN_T - 1);
      SIDE_G:         r = 7'(SIDE_GREEN_T - 1);
      MAIN_Y, SIDE_Y: r = 7'(YELLOW_T - 1);
      RED_A, RED_B:   r = 7'(ALLRED_T - 1);
      WALK:           r = 7'(WALK_T - 1);
      FLASH:          r = 7'(FLASH_T - 1);
      default:        r = 7'(ALLRED_T - 1);
    endcase
    return r;
  endfunction

  state_t     state, state_n;
  logic       blink, blink_n;
  logic       ped_n;
  logic [6:0] ref_n;
  logic       clear_n;
  logic [2:0] main_n, side_n;
  logic       walk_n;
  logic       adv;

  // A trigger coinciding with the restart pulse belongs to the old count.
  assign adv   = tmr.tmr_trigger & ~tmr.tmr_clear;
  assign phase = state;

  always_comb begin
    state_n = state;
    blink_n = blink;
    ref_n   = tmr.tmr_ref;
    clear_n = 1'b0;
    ped_n   = ped_req | ped_pending;

    if (adv) begin
      unique case (state)
        MAIN_G: state_n = MAIN_Y;
        MAIN_Y: state_n = RED_A;
        RED_A:  state_n = flash_mode ? FLASH : SIDE_G;
        SIDE_G: state_n = SIDE_Y;
        SIDE_Y: state_n = RED_B;
        RED_B:  state_n = flash_mode  ? FLASH :
                          ped_pending ? WALK  : MAIN_G;
        WALK:   state_n = MAIN_G;
        FLASH:  state_n = flash_mode ? FLASH : RED_B;
        default: state_n = RED_B;
      endcase

      // Every advance enters a state (FLASH re-enters itself each half-period).
      clear_n = 1'b1;
      ref_n   = dwell_ref(state_n);

      if (state_n == FLASH)
        blink_n = (state == FLASH) ? ~blink : 1'b1;
      else
        blink_n = 1'b0;

      // Entering WALK serves the latch; a request on this same edge re-arms it.
      if (state_n == WALK)
        ped_n = ped_req;
    end

    main_n = LAMP_RED;
    side_n = LAMP_RED;
    walk_n = 1'b0;
    unique case (state_n)
      MAIN_G: main_n = LAMP_GRN;
      MAIN_Y: main_n = LAMP_YEL;
      SIDE_G: side_n = LAMP_GRN;
      SIDE_Y: side_n = LAMP_YEL;
      WALK:   walk_n = 1'b1;
      FLASH: begin
        main_n = blink_n ? LAMP_YEL : LAMP_OFF;
        side_n = blink_n ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RED_B;
      blink         <= 1'b0;
      ped_pending   <= 1'b0;
      tmr.tmr_ref   <= 7'(ALLRED_T - 1);
      tmr.tmr_clear <= 1'b1;
      main_light    <= LAMP_RED;
      side_light    <= LAMP_RED;
      walk          <= 1'b0;
    end else begin
      state         <= state_n;
      blink         <= blink_n;
      ped_pending   <= ped_n;
      tmr.tmr_ref   <= ref_n;
      tmr.tmr_clear <= clear_n;
      main_light    <= main_n;
      side_light    <= side_n;
      walk          <= walk_n;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a behavioural interval
// timer: restart clears the count, and the expiry pulse is raised the cycle
// after the count reaches the reference.
module tb_traffic_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       ped_req;
  logic       flash_mode;
  logic       stray;
  logic       mon_en;
  logic [2:0] main_light, side_light, phase;
  logic       walk, ped_pending;

  logic [2:0] main2, side2, phase2;
  logic       walk2, ped2;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_sequencer_if bus ();
  traffic_phase_sequencer_if bus2 ();

  traffic_phase_sequencer #(
    .MAIN_GREEN_T (2),
    .SIDE_GREEN_T (2),
    .YELLOW_T     (2),
    .ALLRED_T     (2),
    .WALK_T       (3),
    .FLASH_T      (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ped_req     (ped_req),
    .flash_mode  (flash_mode),
    .tmr         (bus.master),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  // Second instance only checks the 128-dwell reference arithmetic.
  traffic_phase_sequencer #(
    .ALLRED_T (128)
  ) dut128 (
    .clock       (clock),
    .reset       (reset),
    .ped_req     (1'b0),
    .flash_mode  (1'b0),
    .tmr         (bus2.master),
    .main_light  (main2),
    .side_light  (side2),
    .walk        (walk2),
    .ped_pending (ped2),
    .phase       (phase2)
  );
  assign bus2.tmr_trigger = 1'b0;

  always #5 clock = ~clock;

  logic [6:0] cnt;
  logic       mtrig;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      mtrig <= 1'b0;
    end else if (bus.tmr_clear) begin
      cnt   <= '0;
      mtrig <= 1'b0;
    end else if (cnt == bus.tmr_ref) begin
      cnt   <= '0;
      mtrig <= 1'b1;
    end else begin
      cnt   <= cnt + 7'd1;
      mtrig <= 1'b0;
    end
  end
  assign bus.tmr_trigger = mtrig | stray;

  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      assert (!(main_light == 3'b001 && side_light == 3'b001)) else begin
        n_fail++;
        $error("FAIL both_green: observed main=%b side=%b required not both 001",
               main_light, side_light);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] p, input logic [2:0] m,
                        input logic [2:0] s, input logic w);
    chk3({tag, ".phase"}, phase, p);
    chk3({tag, ".main"}, main_light, m);
    chk3({tag, ".side"}, side_light, s);
    chk1({tag, ".walk"}, walk, w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [2:0] seq [0:7];
  logic [2:0] mtab [0:6];
  logic [2:0] stab [0:6];

  initial begin
    seq  = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    mtab = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    stab = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    reset      = 1'b1;
    ped_req    = 1'b0;
    flash_mode = 1'b0;
    stray      = 1'b0;
    mon_en     = 1'b1;

    // Reset values
    tick(2);
    chk_st("rst", 3'd5, 3'b100, 3'b100, 1'b0);
    chk1("rst.clear", bus.tmr_clear, 1'b1);
    chk7("rst.ref", bus.tmr_ref, 7'd1);
    chk1("rst.ped", ped_pending, 1'b0);
    chk7("rst.ref128", bus2.tmr_ref, 7'd127);

    // Free run: each state 4 cycles, clear on the first cycle of each (N0..N31)
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick(1);
      chk_st("run", seq[k/4], mtab[seq[k/4]], stab[seq[k/4]], 1'b0);
      chk1("run.clear", bus.tmr_clear, (k % 4) == 0);
      chk7("run.ref", bus.tmr_ref, 7'd1);
    end

    // Pedestrian request during SIDE_G (N40..N43)
    tick(10);                       // N41
    chk3("ped.sideg", phase, 3'd3);
    ped_req = 1'b1;
    tick(1);                        // N42
    ped_req = 1'b0;
    chk1("ped.latched", ped_pending, 1'b1);
    tick(9);                        // N51, last RED_B cycle
    chk3("ped.redb", phase, 3'd5);
    chk1("ped.held", ped_pending, 1'b1);
    tick(1);                        // N52, WALK entry
    chk_st("walk.in", 3'd6, 3'b100, 3'b100, 1'b1);
    chk1("walk.ped", ped_pending, 1'b0);
    chk1("walk.clear", bus.tmr_clear, 1'b1);
    chk7("walk.ref", bus.tmr_ref, 7'd2);
    tick(4);                        // N56, last WALK cycle
    chk_st("walk.end", 3'd6, 3'b100, 3'b100, 1'b1);
    tick(1);                        // N57
    chk_st("walk.out", 3'd0, 3'b001, 3'b100, 1'b0);

    // Flash mode raised mid-MAIN_G
    tick(1);                        // N58
    flash_mode = 1'b1;
    tick(2);                        // N60
    chk_st("fl.green", 3'd0, 3'b001, 3'b100, 1'b0);
    tick(1);                        // N61
    chk_st("fl.yel", 3'd1, 3'b010, 3'b100, 1'b0);
    tick(4);                        // N65
    chk_st("fl.reda", 3'd2, 3'b100, 3'b100, 1'b0);
    tick(4);                        // N69
    chk_st("fl.on", 3'd7, 3'b010, 3'b010, 1'b0);
    chk1("fl.clear", bus.tmr_clear, 1'b1);
    chk7("fl.ref", bus.tmr_ref, 7'd1);
    tick(3);                        // N72
    chk_st("fl.on_end", 3'd7, 3'b010, 3'b010, 1'b0);
    tick(1);                        // N73
    chk_st("fl.off", 3'd7, 3'b000, 3'b000, 1'b0);
    chk1("fl.reclear", bus.tmr_clear, 1'b1);
    tick(4);                        // N77
    chk_st("fl.on2", 3'd7, 3'b010, 3'b010, 1'b0);
    tick(1);                        // N78
    flash_mode = 1'b0;
    tick(3);                        // N81
    chk_st("fl.exit", 3'd5, 3'b100, 3'b100, 1'b0);
    tick(4);                        // N85
    chk_st("fl.main", 3'd0, 3'b001, 3'b100, 1'b0);

    // Request on the exact edge entering WALK
    tick(13);                       // N98, SIDE_G
    ped_req = 1'b1;
    tick(1);                        // N99
    ped_req = 1'b0;
    tick(9);                        // N108, last RED_B cycle
    chk3("rew.redb", phase, 3'd5);
    ped_req = 1'b1;
    tick(1);                        // N109
    ped_req = 1'b0;
    chk3("rew.walk", phase, 3'd6);
    chk1("rew.kept", ped_pending, 1'b1);
    tick(28);                       // N137
    chk3("rew.redb2", phase, 3'd5);
    chk1("rew.kept2", ped_pending, 1'b1);
    tick(1);                        // N138
    chk_st("rew.walk2", 3'd6, 3'b100, 3'b100, 1'b1);
    chk1("rew.served", ped_pending, 1'b0);

    // Asynchronous reset mid-SIDE_Y
    tick(22);                       // N160
    chk_st("ar.sidey", 3'd4, 3'b100, 3'b010, 1'b0);
    reset = 1'b1;
    #1;
    chk_st("ar.async", 3'd5, 3'b100, 3'b100, 1'b0);
    chk1("ar.clear", bus.tmr_clear, 1'b1);
    tick(2);                        // N162
    reset = 1'b0;
    tick(3);                        // N165
    chk3("ar.redb", phase, 3'd5);
    tick(1);                        // N166, MAIN_G clear cycle
    chk_st("ar.main", 3'd0, 3'b001, 3'b100, 1'b0);

    // Stray trigger during the restart cycle is ignored
    chk1("st.clear", bus.tmr_clear, 1'b1);
    stray = 1'b1;
    tick(1);                        // N167
    stray = 1'b0;
    chk3("st.hold", phase, 3'd0);
    tick(3);                        // N170
    chk3("st.next", phase, 3'd1);

    // Random ped_req / flash_mode soak under the both-green monitor
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      ped_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) flash_mode = ~flash_mode;
    end
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
